// File: rtl/handshake_elastic_fifo.sv
// -----------------------------------------------------------------------------
// handshake_elastic_fifo
//
// Multi-slot elastic FIFO for a dataflow valid/ready channel. It decouples a
// producer from a consumer that may stall. Both ins_ready and outs_valid
// come only from registered occupancy, so no combinational valid/ready path
// crosses the buffer.
//
// Handshake semantics (both sides): a token moves on a rising clk edge
// exactly when valid and ready are both 1 in that cycle. A producer that
// raises valid keeps it and its payload steady until the transfer.
// Ready is never a function of the partner's valid. While outs_valid=1 and
// outs_ready=0, outs holds its value.
//
// Parameters:
//   DATA_WIDTH - payload width in bits
//   NUM_SLOTS  - storage depth in tokens (>= 1, any value)
//
// Ports:
//   clk        - single clock, rising-edge active
//   rst        - synchronous active-high reset; discards all buffered tokens
//   ins        - incoming payload
//   ins_valid  - producer offers a token
//   ins_ready  - FIFO has a free slot (state only)
//   outs       - payload at the head of the FIFO
//   outs_valid - FIFO holds at least one token (state only)
//   outs_ready - consumer accepts the head token
//   count      - current occupancy, 0..NUM_SLOTS
// -----------------------------------------------------------------------------
module handshake_elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4,
    localparam int PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_W-1:0]      count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  enq;
    logic                  deq;

    // Explicit wrap compare so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO stays not-ready even when the consumer drains this cycle:
    // the freed slot is offered on the following cycle, which keeps
    // outs_ready out of the ins_ready path.
    assign ins_ready  = (count != FULL_CNT);
    assign outs_valid = (count != '0);
    assign outs       = mem[rd_ptr];

    assign enq = ins_valid & ins_ready;
    assign deq = outs_valid & outs_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (enq) begin
                mem[wr_ptr] <= ins;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// -----------------------------------------------------------------------------
// tb_handshake_elastic_fifo
//
// Two instances share clk/rst:
//   u_dut   : DATA_WIDTH=37, NUM_SLOTS=4 (reset, fill, full+ready, partial
//             occupancy streaming, mid-operation reset)
//   u_dut_b : DATA_WIDTH=8,  NUM_SLOTS=3 (streaming with wrap-around and a
//             randomly stalling consumer)
// Drivers push the expected token into a queue at the accepting edge; a
// monitor per instance pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_handshake_elastic_fifo;

    localparam int W_A = 37;
    localparam int W_B = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A ----------------
    logic [W_A-1:0] ins = '0;
    logic           ins_valid = 1'b0;
    logic           ins_ready;
    logic [W_A-1:0] outs;
    logic           outs_valid;
    logic           outs_ready = 1'b0;
    logic [2:0]     count;

    handshake_elastic_fifo #(.DATA_WIDTH(W_A), .NUM_SLOTS(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .count      (count)
    );

    // ---------------- DUT B ----------------
    logic [W_B-1:0] b_ins = '0;
    logic           b_ins_valid = 1'b0;
    logic           b_ins_ready;
    logic [W_B-1:0] b_outs;
    logic           b_outs_valid;
    logic           b_outs_ready = 1'b0;
    logic [1:0]     b_count;

    handshake_elastic_fifo #(.DATA_WIDTH(W_B), .NUM_SLOTS(3)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .ins        (b_ins),
        .ins_valid  (b_ins_valid),
        .ins_ready  (b_ins_ready),
        .outs       (b_outs),
        .outs_valid (b_outs_valid),
        .outs_ready (b_outs_ready),
        .count      (b_count)
    );

    // ---------------- scoreboard state ----------------
    logic [W_A-1:0] exp_q[$];
    logic [W_B-1:0] exp_b_q[$];
    int tests = 0;
    int fails = 0;
    int rx_b  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    logic           a_stall_prev = 1'b0;
    logic [W_A-1:0] a_hold = '0;
    logic           b_stall_prev = 1'b0;
    logic [W_B-1:0] b_hold = '0;

    always @(negedge clk) begin
        if (!rst && outs_valid && outs_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL a_unexpected_out: got %0h, expected no token at %0t", outs, $time);
            end else begin
                check("a_out_order", 64'(outs), 64'(exp_q.pop_front()));
            end
        end
        if (!rst && a_stall_prev && outs_valid)
            check("a_hold_stable", 64'(outs), 64'(a_hold));
        a_stall_prev = !rst && outs_valid && !outs_ready;
        a_hold       = outs;
    end

    always @(negedge clk) begin
        if (!rst && b_outs_valid && b_outs_ready) begin
            rx_b++;
            if (exp_b_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL b_unexpected_out: got %0h, expected no token at %0t", b_outs, $time);
            end else begin
                check("b_out_order", 64'(b_outs), 64'(exp_b_q.pop_front()));
            end
        end
        if (!rst && b_stall_prev && b_outs_valid)
            check("b_hold_stable", 64'(b_outs), 64'(b_hold));
        b_stall_prev = !rst && b_outs_valid && !b_outs_ready;
        b_hold       = b_outs;
    end

    // ---------------- driver tasks ----------------
    // Called and returning at #1 after a rising edge; returns #1 after the
    // edge that accepted the token.
    task automatic send(input logic [W_A-1:0] v);
        bit done = 1'b0;
        ins       = v;
        ins_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (ins_ready) begin
                exp_q.push_back(v);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("a_send_timeout", 64'(0), 64'(1));
        ins_valid = 1'b0;
    endtask

    task automatic send_b(input logic [W_B-1:0] v);
        bit done = 1'b0;
        b_ins       = v;
        b_ins_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            b_outs_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b_ins_ready) begin
                exp_b_q.push_back(v);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("b_send_timeout", 64'(0), 64'(1));
        b_ins_valid = 1'b0;
    endtask

    task automatic drain_a();
        bit done = 1'b0;
        outs_ready = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            if (count == 3'd0) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("a_drain_done", 64'(done), 64'(1));
        check("a_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held for two edges; observe outputs while it is asserted.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_outs_valid", 64'(outs_valid), 64'(0));
        check("rst_ins_ready",  64'(ins_ready),  64'(1));
        check("rst_count",      64'(count),      64'(0));
        check("rst_outs",       64'(outs),       64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ins_ready",  64'(ins_ready),  64'(1));
        check("post_rst_outs_valid", 64'(outs_valid), 64'(0));
        @(posedge clk); #1;

        // Single 37-bit token: visible one cycle after acceptance, then drains.
        outs_ready = 1'b1;
        send(37'h0DD4A7055);
        check("single_outs_valid", 64'(outs_valid), 64'(1));
        check("single_outs",       64'(outs),       64'h0DD4A7055);
        check("single_count",      64'(count),      64'(1));
        @(posedge clk); #1;
        check("single_drained_count", 64'(count),      64'(0));
        check("single_drained_valid", 64'(outs_valid), 64'(0));

        // Fill to full with a stalled consumer.
        outs_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            send(W_A'(v));
            check("fill_count", 64'(count), 64'(v));
        end
        check("full_ins_ready", 64'(ins_ready), 64'(0));
        ins       = 37'd5;
        ins_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("full_reject_ready", 64'(ins_ready), 64'(0));
            @(posedge clk); #1;
        end
        check("full_reject_count", 64'(count), 64'(4));
        check("full_head",         64'(outs),  64'(1));

        // Full with consumer ready: no enqueue this cycle, 9 accepted next.
        ins        = 37'd9;
        outs_ready = 1'b1;
        @(negedge clk);
        check("full_ready_no_enq", 64'(ins_ready), 64'(0));
        @(posedge clk); #1;
        check("full_ready_count",     64'(count),     64'(3));
        check("full_ready_ins_ready", 64'(ins_ready), 64'(1));
        send(37'd9);
        check("stream_count_9", 64'(count), 64'(3));
        send(37'd10);
        check("stream_count_10", 64'(count), 64'(3));
        send(37'd11);
        check("stream_count_11", 64'(count), 64'(3));
        drain_a();

        // Simultaneous enqueue/dequeue at occupancy 2.
        outs_ready = 1'b0;
        send(37'd20);
        send(37'd21);
        check("partial_count_init", 64'(count), 64'(2));
        outs_ready = 1'b1;
        for (int v = 22; v <= 26; v++) begin
            send(W_A'(v));
            check("partial_count_hold", 64'(count), 64'(2));
        end

        // Reset mid-operation at occupancy 3, with enq and deq both requested.
        outs_ready = 1'b0;
        send(37'd27);
        check("pre_rst_count", 64'(count), 64'(3));
        rst        = 1'b1;
        ins        = 37'h1FFFFFFFFF;
        ins_valid  = 1'b1;
        outs_ready = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst       = 1'b0;
        ins_valid = 1'b0;
        check("mid_rst_count",      64'(count),      64'(0));
        check("mid_rst_outs_valid", 64'(outs_valid), 64'(0));
        check("mid_rst_outs",       64'(outs),       64'(0));
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_stays_empty", 64'(outs_valid), 64'(0));
        send(37'h12345ABCD);
        drain_a();

        // DUT B: 10 consecutive tokens through a 3-slot FIFO, random stalls.
        for (int v = 0; v < 10; v++) send_b(W_B'(v));
        begin
            bit done = 1'b0;
            for (int n = 0; n < 200 && !done; n++) begin
                if (b_count == 2'd0) done = 1'b1;
                else begin
                    b_outs_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            check("b_drain_done", 64'(done), 64'(1));
        end
        check("b_rx_count",    64'(rx_b),            64'(10));
        check("b_queue_empty", 64'(exp_b_q.size()),  64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/handshake_elastic_fifo.md
# handshake_elastic_fifo

Multi-slot elastic FIFO placed on a dataflow handshake channel. It decouples a producer, typically a handshake constant whose `outs`/`outs_valid` follow its control token, from a consumer that may stall. Its ready and valid outputs are both registered-state driven, which breaks every combinational valid/ready path between the two sides. It preserves token order and carries arbitrary `DATA_WIDTH` payloads, including wide constants such as 37-bit words.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits.
- `NUM_SLOTS`, default 4: storage depth in tokens. Legal values are ≥1 and need not be a power of two.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `ins` input, `DATA_WIDTH` bits: incoming payload.
- `ins_valid` input, 1 bit: producer offers a token.
- `ins_ready` output, 1 bit: FIFO accepts a token this cycle.
- `outs` output, `DATA_WIDTH` bits: payload at the head of the FIFO.
- `outs_valid` output, 1 bit: head token is available.
- `outs_ready` input, 1 bit: consumer accepts the head token.
- `count` output, `$clog2(NUM_SLOTS+1)` bits: current occupancy, 0..`NUM_SLOTS`.

## Operation
- Storage is a register array `mem[0..NUM_SLOTS-1]` with write pointer `wr_ptr`, read pointer `rd_ptr`, both `$clog2(NUM_SLOTS)` bits (min 1), plus occupancy `count`.
- Definitions: enqueue `enq = ins_valid & ins_ready`; dequeue `deq = outs_valid & outs_ready`.
- `ins_ready = (count != NUM_SLOTS)`. Depends on state only, never on `outs_ready` or `ins_valid`.
- `outs_valid = (count != 0)`. Depends on state only, never on `ins_valid`.
- `outs = mem[rd_ptr]`. This is a combinational read of registered storage.
- On `enq`: `mem[wr_ptr] <= ins`, and `wr_ptr` advances.
- On `deq`: `rd_ptr` advances.
- Pointer advance: `NUM_SLOTS-1` wraps to 0, otherwise increment. Explicit compare, not natural overflow, so non-power-of-two depths are correct.
- `count` update:
  - `enq` and `deq` together: `count` unchanged, both pointers advance.
  - `enq` only: +1.
  - `deq` only: −1.
- Full with `outs_ready=1`: `ins_ready` stays 0 that cycle. There is no same-cycle pass-through of a freed slot; the producer is accepted the following cycle.
- Empty with `ins_valid=1`: there is no bypass. The token is written and appears on `outs` with `outs_valid=1` the next cycle.
- Reset:
  - `wr_ptr`, `rd_ptr` and `count` go to 0, and all `mem` entries clear to 0.
  - Hence after reset: `outs_valid=0`, `ins_ready=1`, `outs=0`, `count=0`.
- Reset mid-operation: all buffered tokens are discarded. Reset has priority over any `enq`/`deq` in the same cycle.
- `ins` is ignored when `enq` is 0. `mem` holds its contents when not written.
- `outs` is stable while `outs_valid=1` and `outs_ready=0`, per the handshake persistence rule.

## Timing
- Latency: a token accepted at edge N is visible on `outs` after edge N, so one cycle minimum.
- Throughput: one token per cycle sustained when neither side stalls and `NUM_SLOTS` ≥ 2.
- `NUM_SLOTS=1` alternates fill/drain: at most one token every 2 cycles.
- No combinational path from `outs_ready` to `ins_ready`, or from `ins_valid` to `outs_valid`.
- The only input→output combinational path is none: all outputs are functions of registers.
- First cycle after `rst` deasserts: `ins_ready=1`, `outs_valid=0`.

## Test plan
- Reset and single token:
  - Stimulus: assert `rst` for 2 cycles, then `ins=37'h0DD4A7055` with `ins_valid=1` for one cycle, `outs_ready=1`, `DATA_WIDTH=37`.
  - Response: during reset `outs_valid=0`, `ins_ready=1`, `count=0`. One cycle after the enqueue, `outs=37'h0DD4A7055` and `outs_valid=1`. It drains the next edge, then `count=0`.
- Fill to full, `NUM_SLOTS=4`:
  - Stimulus: write 1,2,3,4 with `outs_ready=0`.
  - Response: `count` steps 1..4 and `ins_ready=0` at `count=4`. A 5th value presented with `ins_valid=1` is not accepted. Draining then yields exactly 1,2,3,4.
- Full with simultaneous ready:
  - Stimulus: at `count=4`, raise `outs_ready=1` and `ins_valid=1` with value 9.
  - Response: no enqueue that cycle and `count` becomes 3. Value 9 is accepted the following cycle, so `count` stays 3 from then on while streaming.
- Streaming with wrap-around, `NUM_SLOTS=3`:
  - Stimulus: 10 consecutive tokens 0..9 with random `outs_ready` (~50%).
  - Response: output order is 0..9 with no loss or duplication. Pointers wrap past index 2 correctly. `outs` is held stable during stalls.
- Simultaneous enqueue/dequeue at partial occupancy:
  - Stimulus: `count=2`, `ins_valid=1`, `outs_ready=1` for 5 cycles.
  - Response: `count` stays 2 and each output equals the input from 2 accepts earlier.
- Reset mid-operation:
  - Stimulus: `count=3`, assert `rst` for one cycle together with `ins_valid=1` and `outs_ready=1`.
  - Response: after the edge `count=0`, `outs_valid=0`, `outs=0`, and none of the old tokens ever appear on `outs`.
